// File: rtl/sqrt_pkg.sv
// Shared encodings for the iterative square-root datapath and its control FSM.
package sqrt_pkg;

  typedef enum logic [1:0] {
    FLAG_DONE = 2'b00,
    FLAG_EQ   = 2'b01,
    FLAG_LT   = 2'b10,
    FLAG_RSVD = 2'b11
  } flag_e;

  localparam logic SEL_INIT = 1'b0;
  localparam logic SEL_ITER = 1'b1;

endpackage

// File: rtl/sqrt_datapath_if.sv
// Strobe/flag bundle between the square-root control FSM (master) and datapath (slave).
interface sqrt_datapath_if #(
  parameter int WIDTH = 8
);
  localparam int RW = WIDTH / 2;

  logic [WIDTH-1:0] x_i;
  logic             boot_i;
  logic             muxes_i;
  logic             wr_root_i;
  logic             wr_square_i;
  logic             root_i;
  logic             ready_i;
  logic [1:0]       N_o;
  logic [RW-1:0]    root_o;
  logic             valid_o;

  modport master (
    output x_i, boot_i, muxes_i, wr_root_i, wr_square_i, root_i, ready_i,
    input  N_o, root_o, valid_o
  );

  modport slave (
    input  x_i, boot_i, muxes_i, wr_root_i, wr_square_i, root_i, ready_i,
    output N_o, root_o, valid_o
  );

endinterface

// File: rtl/sqrt_compare.sv
// Pure comparator: relates the running square (root+1)^2 to the radicand.
module sqrt_compare
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH+1:0] i_sq,
  input  logic [WIDTH-1:0] i_x,
  input  logic             i_ovf,
  output flag_e            o_flag
);

  logic [WIDTH+1:0] w_x_ext;

  assign w_x_ext = {2'b00, i_x};

  // A root that has run past RW bits can only mean the loop overshot; report done.
  always_comb begin
    o_flag = FLAG_LT;
    if (i_ovf)                o_flag = FLAG_DONE;
    else if (i_sq > w_x_ext)  o_flag = FLAG_DONE;
    else if (i_sq == w_x_ext) o_flag = FLAG_EQ;
  end

endmodule

// File: rtl/sqrt_datapath.sv
// Odd-number accumulation square root: root counts up while (root+1)^2 <= x.
module sqrt_datapath
  import sqrt_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic            clk,
  input logic            rst_n,
  sqrt_datapath_if.slave bus
);

  localparam int RW = WIDTH / 2;

  if (WIDTH < 2 || (WIDTH % 2) != 0) begin : g_bad_width
    $error("sqrt_datapath: WIDTH must be even and >= 2");
  end

  logic [WIDTH-1:0] r_x;
  logic [RW:0]      r_root;
  logic [WIDTH+1:0] r_sq;
  logic [RW-1:0]    r_res;
  logic             r_valid;

  logic [WIDTH+1:0] w_sq_next;
  logic [RW:0]      w_root_next;
  flag_e            w_flag;

  // (r+2)^2 = (r+1)^2 + 2r + 3, always formed from the pre-update root.
  assign w_sq_next   = r_sq + {{(WIDTH - RW){1'b0}}, r_root, 1'b0} + (WIDTH + 2)'(3);
  assign w_root_next = r_root + {{RW{1'b0}}, bus.root_i};

  sqrt_compare #(
    .WIDTH (WIDTH)
  ) u_compare (
    .i_sq   (r_sq),
    .i_x    (r_x),
    .i_ovf  (r_root[RW]),
    .o_flag (w_flag)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x     <= '0;
      r_root  <= '0;
      r_sq    <= (WIDTH + 2)'(1);
      r_res   <= '0;
      r_valid <= 1'b0;
    end else if (bus.boot_i) begin
      r_x     <= bus.x_i;
      r_root  <= '0;
      r_sq    <= (WIDTH + 2)'(1);
      r_valid <= 1'b0;
    end else begin
      if (bus.wr_square_i)
        r_sq <= (bus.muxes_i == SEL_ITER) ? w_sq_next : (WIDTH + 2)'(1);
      if (bus.wr_root_i)
        r_root <= (bus.muxes_i == SEL_ITER) ? w_root_next : '0;
      if (bus.ready_i && w_flag == FLAG_DONE) begin
        r_res   <= r_root[RW-1:0];
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.N_o     = w_flag;
  assign bus.root_o  = r_res;
  assign bus.valid_o = r_valid;

  // Selects may float while their enables are low, never while they are used.
  always @(posedge clk) begin
    if (rst_n && !bus.boot_i) begin
      if (bus.wr_root_i)
        assert (!$isunknown({bus.muxes_i, bus.root_i}));
      if (bus.wr_square_i)
        assert (!$isunknown(bus.muxes_i));
    end
    assert (w_flag != FLAG_RSVD);
  end

endmodule

// File: tb/tb_sqrt_datapath.sv
// Bench for sqrt_datapath: vector table of radicands plus hand-built corner sequences.
module tb_sqrt_datapath;
  import sqrt_pkg::*;

  localparam int WIDTH = 8;
  localparam int RW    = WIDTH / 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sqrt_datapath_if #(.WIDTH(WIDTH)) bus ();

  sqrt_datapath #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [1:0]    n;
    logic [RW-1:0] root;
    logic          valid;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    int x;
    int root;
  } vec_t;
  vec_t vecs[11];

  int m_x, m_root, m_sq, m_res;
  bit m_valid;

  function automatic logic [1:0] model_n();
    if (m_root >= (1 << RW)) return 2'b00;
    if (m_sq > m_x)          return 2'b00;
    if (m_sq == m_x)         return 2'b01;
    return 2'b10;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic model_reset();
    m_x = 0; m_root = 0; m_sq = 1; m_res = 0; m_valid = 1'b0;
  endtask

  task automatic drive_idle();
    bus.x_i = '0; bus.boot_i = 0; bus.muxes_i = 0; bus.wr_root_i = 0;
    bus.wr_square_i = 0; bus.root_i = 0; bus.ready_i = 0;
  endtask

  task automatic step(input logic boot, input logic [WIDTH-1:0] x, input logic mux,
                      input logic wr_r, input logic wr_s, input logic rt,
                      input logic rdy, input string tag);
    logic [1:0] n_cur;
    int old;
    exp_t e;
    bus.boot_i = boot; bus.x_i = x; bus.muxes_i = mux; bus.wr_root_i = wr_r;
    bus.wr_square_i = wr_s; bus.root_i = rt; bus.ready_i = rdy;
    @(posedge clk);
    n_cur = model_n();
    if (boot) begin
      m_x = int'(x); m_root = 0; m_sq = 1; m_valid = 1'b0;
    end else begin
      old = m_root;
      if (wr_s) m_sq = mux ? m_sq + 2 * old + 3 : 1;
      if (wr_r) m_root = mux ? old + int'(rt) : 0;
      if (rdy && n_cur == 2'b00) begin
        m_res = old % (1 << RW);
        m_valid = 1'b1;
      end
    end
    sb.push_back('{model_n(), m_res[RW-1:0], m_valid});
    #1;
    e = sb.pop_front();
    check({tag, ".N"},     32'(bus.N_o),     32'(e.n));
    check({tag, ".root"},  32'(bus.root_o),  32'(e.root));
    check({tag, ".valid"}, 32'(bus.valid_o), 32'(e.valid));
  endtask

  task automatic iterate(input string tag);
    step(0, '0, 1, 1, 1, 1, 0, tag);
  endtask

  task automatic run_vec(input int x, input int exp_root);
    int n;
    step(1, WIDTH'(x), 0, 0, 0, 0, 0, "boot");
    n = 0;
    while (model_n() != 2'b00 && n < 40) begin
      iterate("iter");
      n++;
    end
    check($sformatf("updates(x=%0d)", x), 32'(n), 32'(exp_root));
    step(0, '0, 0, 0, 0, 0, 1, "ready");
    check($sformatf("root(x=%0d)", x), 32'(bus.root_o), 32'(exp_root));
    check($sformatf("valid(x=%0d)", x), 32'(bus.valid_o), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] nseq [4];
    logic [1:0] n_hold;

    vecs[0]  = '{0, 0};    vecs[1]  = '{1, 1};    vecs[2]  = '{2, 1};
    vecs[3]  = '{15, 3};   vecs[4]  = '{16, 4};   vecs[5]  = '{17, 4};
    vecs[6]  = '{100, 10}; vecs[7]  = '{200, 14}; vecs[8]  = '{224, 14};
    vecs[9]  = '{225, 15}; vecs[10] = '{255, 15};
    nseq = '{2'b10, 2'b10, 2'b01, 2'b00};

    drive_idle();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("reset.N",     32'(bus.N_o),     32'd0);
    check("reset.root",  32'(bus.root_o),  32'd0);
    check("reset.valid", 32'(bus.valid_o), 32'd0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i].x, vecs[i].root);

    // x=16 flag sequence against literal expectations
    step(1, 8'd16, 0, 0, 0, 0, 0, "b16");
    check("x16.N0", 32'(bus.N_o), 32'(2'b10));
    for (int i = 0; i < 4; i++) begin
      iterate("x16");
      check($sformatf("x16.N%0d", i + 1), 32'(bus.N_o), 32'(nseq[i]));
    end
    step(0, '0, 0, 0, 0, 0, 1, "x16.rdy");
    check("x16.root", 32'(bus.root_o), 32'd4);

    // re-boot mid-run wins over simultaneous strobes
    step(1, 8'd200, 0, 0, 0, 0, 0, "b200");
    for (int i = 0; i < 5; i++) iterate("i200");
    step(1, 8'd9, 1, 1, 1, 1, 1, "reboot");
    check("reboot.valid", 32'(bus.valid_o), 32'd0);
    check("reboot.N",     32'(bus.N_o),     32'(2'b10));
    for (int i = 0; i < 3; i++) iterate("i9");
    step(0, '0, 0, 0, 0, 0, 1, "x9.rdy");
    check("x9.root", 32'(bus.root_o), 32'd3);

    // ready while not done is ignored, then async reset mid-iteration
    step(1, 8'd200, 0, 0, 0, 0, 0, "b200b");
    step(0, '0, 0, 0, 0, 0, 1, "early.rdy");
    check("early.valid", 32'(bus.valid_o), 32'd0);
    for (int i = 0; i < 3; i++) iterate("i200b");
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check("arst.N",     32'(bus.N_o),     32'd0);
    check("arst.root",  32'(bus.root_o),  32'd0);
    check("arst.valid", 32'(bus.valid_o), 32'd0);
    drive_idle();
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    step(0, '0, 0, 0, 0, 0, 1, "post.rdy");
    check("post.root",  32'(bus.root_o),  32'd0);
    check("post.valid", 32'(bus.valid_o), 32'd1);

    // unknown selects with enables low must not disturb anything
    step(1, 8'd50, 0, 0, 0, 0, 0, "b50");
    for (int i = 0; i < 3; i++) iterate("i50");
    n_hold = bus.N_o;
    for (int i = 0; i < 10; i++) begin
      step(0, '0, 1'bx, 0, 0, 1'bx, 0, "xsel");
      check("xsel.Nstable", 32'(bus.N_o), 32'(2'b10));
    end
    check("xsel.Nhold", 32'(bus.N_o), 32'(n_hold));
    for (int i = 0; i < 4; i++) iterate("i50b");
    check("x50.Ndone", 32'(bus.N_o), 32'd0);
    step(0, '0, 0, 0, 0, 0, 1, "x50.rdy");
    check("x50.root", 32'(bus.root_o), 32'd7);

    drive_idle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sqrt_datapath.md
Name: sqrt_datapath

Overview:
Iterative integer square-root datapath that sits directly downstream of the square-root control FSM. It consumes that FSM's control strobes (boot, muxes, ready, wr_root, wr_square, root) and returns the 2-bit comparison flag N that the FSM branches on. Algorithm: odd-number accumulation. root r counts up while (r+1)^2 <= x; the result is floor(sqrt(x)).

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2.
RW (derived, localparam), WIDTH/2, result width.

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
x_i  in  WIDTH  radicand; sampled only on boot_i
boot_i  in  1  load x_i and initialise root/square registers
muxes_i  in  1  next-value source select: 0 = init constants, 1 = iterate
wr_root_i  in  1  write enable, root register
wr_square_i  in  1  write enable, square register
root_i  in  1  root increment select: 1 = +1, 0 = hold current value
ready_i  in  1  result capture strobe
N_o  out  2  comparison flag to the control FSM
root_o  out  RW  captured result
valid_o  out  1  root_o holds the result for the current radicand

Behaviour:
- Registers: x_q[WIDTH], root_q[RW+1], sq_q[WIDTH+2] (holds (root_q+1)^2), res_q[RW], valid_q.
- Reset (async, rst_n=0): x_q=0, root_q=0, sq_q=1, res_q=0, valid_q=0. Therefore N_o=2'b00 during reset (1 > 0), root_o=0, valid_o=0.
- boot_i=1 has the highest priority. x_q<=x_i, root_q<=0, sq_q<=1, valid_q<=0. All other strobes are ignored that cycle.
- wr_square_i=1 (no boot): sq_q <= muxes_i ? sq_q + 2*root_q + 3 : 1.
- wr_root_i=1 (no boot): root_q <= muxes_i ? root_q + root_i : 0.
- When wr_root_i and wr_square_i are both asserted with muxes_i=1 and root_i=1, the square update uses the pre-update root_q. Both registers advance consistently within one cycle.
- ready_i=1, N_o==2'b00, no boot: res_q<=root_q[RW-1:0], valid_q<=1.
  - valid_q stays set until the next boot or reset.
  - ready_i with N_o!=2'b00 changes nothing.
- N_o is combinational from registers only, with zero-cycle latency after any register update:
  - 2'b00: sq_q > x_q (done)
  - 2'b01: sq_q == x_q
  - 2'b10: sq_q < x_q
  - 2'b11: never driven
- Overflow guard: if root_q[RW]=1, N_o is forced to 2'b00. This is unreachable under legal sequencing. sq_q width WIDTH+2 covers the maximum value 2^WIDTH + 2^(RW+1) + 1.
- Iteration count: floor(sqrt(x)) root/square updates from boot to N_o=00.
- X-tolerance: muxes_i and root_i may be X when their write enables are 0; no register may capture X. A simulation assertion fires if an enable is 1 while its select is X.
- Reset mid-operation: clears immediately (asynchronous); no partial result is visible.
- Re-boot mid-operation: restarts cleanly; valid_o drops the next cycle.

Decomposition:
- Package sqrt_pkg: flag encodings FLAG_DONE=2'b00, FLAG_EQ=2'b01, FLAG_LT=2'b10, FLAG_RSVD=2'b11; mux select constants SEL_INIT=0, SEL_ITER=1.
- Sub-module sqrt_compare: pure comparator (sq, x, overflow bit) -> N flag.
- Registers and adders live in sqrt_datapath.

Test Plan:
1. WIDTH=8, boot x=0 -> N_o=00 the cycle after boot; ready_i -> root_o=0, valid_o=1.
2. Boot x=16, drive iterate strobes (wr_root=wr_square=1, muxes=1, root=1):
   - N_o sequence 10,10,10,01 (sq_q=1,4,9,16);
   - after the 4th update sq_q=25, N_o=00; ready -> root_o=4.
3. Boot x=15 -> 3 updates then N_o=00; root_o=3. Boot x=255 -> 15 updates; root_o=15, sq_q=256, no overflow.
4. After iterating x=200, mid-run assert boot with x=9 and wr strobes=1:
   - boot wins; valid_o=0; root_q=0;
   - result 3 after 3 updates.
5. Pull rst_n low asynchronously mid-iteration (between clock edges) -> all outputs reset immediately; no capture on the following ready_i while N_o!=00 ... N_o=00 with root 0 gives root_o=0.
6. Drive muxes_i=X and root_i=X with write enables 0 for 10 cycles -> registers unchanged, N_o stable, no assertion; enable wr_root_i with root_i=X -> assertion fires.
